// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one synchronous single-port SRAM between a fetch port and a data port.
// Latency: grant is combinational in IDLE; read data returns 1+WAIT_STATES cycles after grant.
// Backpressure: req/gnt handshake, requests are not buffered; the port is busy for WAIT_STATES cycles per access.
//
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN -- alternate priority under contention
// (undefined: data always beats fetch).
// Ports: clk_i/rst_i (async, active-low); if_* fetch requester (read only);
//        d_* data requester (read/write, byte enables); mem_* SRAM side; busy_o = no grant possible.
module sram_arbiter #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_sel_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [31:0] d_rdata_o,
   output logic        mem_ce_o,
   output logic [3:0]  mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   localparam logic [2:0] WS = 3'(WAIT_STATES);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;     // 1 = fetch owns the access in flight
   logic        read_q, read_d;
   logic [31:0] addr_q, addr_d;
   logic        rv_q, rv_d;           // read data returns this cycle
   logic        rv_own_q, rv_own_d;   // 1 = returning data belongs to fetch

   logic        data_first;
   logic        grant_data;
   logic        grant_fetch;
   logic        write_now;
   logic        in_wait;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   // Records the last winner: 1 = data won last, so fetch wins the next contention.
   // Reset value 0 therefore favours data.
   logic ptr_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ptr_q <= 1'b0;
      end else if (grant_data || grant_fetch) begin
         ptr_q <= grant_data;
      end
   end

   assign data_first = ~ptr_q;
`else
   assign data_first = 1'b1;
`endif

   assign in_wait = (state_q == WAIT);

   // Gating with rst_i keeps every output low while reset is held, even with requests present.
   assign grant_data  = rst_i && (state_q == IDLE) && d_req_i && (!if_req_i || data_first);
   assign grant_fetch = rst_i && (state_q == IDLE) && if_req_i && !grant_data;
   assign write_now   = grant_data && d_we_i;

   assign if_gnt_o    = grant_fetch;
   assign d_gnt_o     = grant_data;
   assign busy_o      = in_wait;
   assign mem_ce_o    = grant_data || grant_fetch || in_wait;
   assign mem_we_o    = write_now ? d_sel_i : 4'b0000;
   assign mem_wdata_o = write_now ? d_wdata_i : 32'd0;
   assign mem_addr_o  = grant_data  ? d_addr_i  :
                        grant_fetch ? if_addr_i :
                        in_wait     ? addr_q    : 32'd0;

   assign if_rvalid_o = rv_q && rv_own_q;
   assign d_rvalid_o  = rv_q && !rv_own_q;
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
   assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : 32'd0;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         owner_q  <= 1'b0;
         read_q   <= 1'b0;
         addr_q   <= 32'd0;
         rv_q     <= 1'b0;
         rv_own_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         read_q   <= read_d;
         addr_q   <= addr_d;
         rv_q     <= rv_d;
         rv_own_q <= rv_own_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      read_d   = read_q;
      addr_d   = addr_q;
      rv_d     = 1'b0;
      rv_own_d = rv_own_q;
      case (state_q)
         IDLE: begin
            if (grant_data || grant_fetch) begin
               owner_d = grant_fetch;
               read_d  = grant_fetch || !d_we_i;
               addr_d  = grant_fetch ? if_addr_i : d_addr_i;
               cnt_d   = WS;
               if (WS == 3'd0) begin
                  // Zero wait states: stay in IDLE, data comes back next cycle (pipelined).
                  rv_d     = read_d;
                  rv_own_d = grant_fetch;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               // Last extra cycle: SRAM output is valid on the next cycle, which is IDLE again.
               state_d  = IDLE;
               rv_d     = read_q;
               rv_own_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: three arbiter instances (WAIT_STATES 0, 2, 3) each with its own SRAM model.
// Directed scenarios plus a randomized run compared against a cycle-count scoreboard model.
module tb_sram_arbiter;

   localparam int NI = 3;

   function automatic int ws_of(input int i);
      return (i == 0) ? 0 : (i == 1) ? 2 : 3;
   endfunction

   function automatic logic [31:0] init_word(input int k);
      logic [7:0] b;
      b = k[7:0];
      return {8'h5A, b, ~b, b + 8'h11};
   endfunction

   typedef struct {
      int          cyc;
      bit          own_d;
      logic [31:0] dat;
   } rv_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_init;

   logic        if_req    [NI];
   logic [31:0] if_addr   [NI];
   logic        if_gnt    [NI];
   logic        if_rvalid [NI];
   logic [31:0] if_rdata  [NI];
   logic        d_req     [NI];
   logic        d_we      [NI];
   logic [3:0]  d_sel     [NI];
   logic [31:0] d_addr    [NI];
   logic [31:0] d_wdata   [NI];
   logic        d_gnt     [NI];
   logic        d_rvalid  [NI];
   logic [31:0] d_rdata   [NI];
   logic        mem_ce    [NI];
   logic [3:0]  mem_we    [NI];
   logic [31:0] mem_addr  [NI];
   logic [31:0] mem_wdata [NI];
   logic        busy      [NI];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [31:0] mem [256];
      logic [31:0] rd;

      sram_arbiter #(.WAIT_STATES(ws_of(g))) u_dut (
         .clk_i       (clk),
         .rst_i       (rst_n),
         .if_req_i    (if_req[g]),
         .if_addr_i   (if_addr[g]),
         .if_gnt_o    (if_gnt[g]),
         .if_rvalid_o (if_rvalid[g]),
         .if_rdata_o  (if_rdata[g]),
         .d_req_i     (d_req[g]),
         .d_we_i      (d_we[g]),
         .d_sel_i     (d_sel[g]),
         .d_addr_i    (d_addr[g]),
         .d_wdata_i   (d_wdata[g]),
         .d_gnt_o     (d_gnt[g]),
         .d_rvalid_o  (d_rvalid[g]),
         .d_rdata_o   (d_rdata[g]),
         .mem_ce_o    (mem_ce[g]),
         .mem_we_o    (mem_we[g]),
         .mem_addr_o  (mem_addr[g]),
         .mem_wdata_o (mem_wdata[g]),
         .mem_rdata_i (rd),
         .busy_o      (busy[g])
      );

      // Synchronous single-port SRAM, word index = addr[9:2], read-before-write.
      always @(posedge clk) begin
         if (mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
         end else if (mem_ce[g]) begin
            for (int b = 0; b < 4; b++)
               if (mem_we[g][b]) mem[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            rd <= mem[mem_addr[g][9:2]];
         end
      end
   end

   function automatic logic [137:0] outs_of(input int i);
      return {if_gnt[i], if_rvalid[i], if_rdata[i], d_gnt[i], d_rvalid[i], d_rdata[i],
              mem_ce[i], mem_we[i], mem_addr[i], mem_wdata[i], busy[i]};
   endfunction

   task automatic clear_inputs();
      for (int i = 0; i < NI; i++) begin
         if_req[i] = 1'b0; if_addr[i] = 32'd0;
         d_req[i] = 1'b0; d_we[i] = 1'b0; d_sel[i] = 4'd0; d_addr[i] = 32'd0; d_wdata[i] = 32'd0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      clear_inputs();
      mem_init = 1'b1;
      tick();
      mem_init = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Outputs must be 0 while reset is held, even with every request asserted.
   task automatic test_reset();
      for (int i = 0; i < NI; i++) begin
         if_req[i] = 1'b1; if_addr[i] = 32'h0000_0010;
         d_req[i] = 1'b1; d_we[i] = 1'b1; d_sel[i] = 4'hF; d_addr[i] = 32'h0000_0020; d_wdata[i] = 32'hCAFE_F00D;
      end
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         n_tests++;
         if (outs_of(i) !== 138'd0) begin
            n_fail++; $display("FAIL reset_outs[%0d]: got %h want 0", i, outs_of(i));
         end
      end
   endtask

   // WAIT_STATES=0: back-to-back fetches to 0x100 and 0x104.
   task automatic test_pipelined_fetch();
      if_req[0] = 1'b1; if_addr[0] = 32'h100;
      @(negedge clk);
      n_tests++; if (if_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL pf_gnt_T: got %b want 1", if_gnt[0]); end
      n_tests++; if (mem_addr[0] !== 32'h100) begin n_fail++; $display("FAIL pf_addr_T: got %h want 100", mem_addr[0]); end
      n_tests++; if (if_rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL pf_rv_T: got %b want 0", if_rvalid[0]); end
      tick();
      if_addr[0] = 32'h104;
      @(negedge clk);
      n_tests++; if (if_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL pf_gnt_T1: got %b want 1", if_gnt[0]); end
      n_tests++; if (if_rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL pf_rv_T1: got %b want 1", if_rvalid[0]); end
      n_tests++; if (if_rdata[0] !== init_word(32'h40)) begin n_fail++; $display("FAIL pf_data_T1: got %h want %h", if_rdata[0], init_word(32'h40)); end
      tick();
      if_req[0] = 1'b0;
      @(negedge clk);
      n_tests++; if (if_rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL pf_rv_T2: got %b want 1", if_rvalid[0]); end
      n_tests++; if (if_rdata[0] !== init_word(32'h41)) begin n_fail++; $display("FAIL pf_data_T2: got %h want %h", if_rdata[0], init_word(32'h41)); end
      n_tests++; if (mem_ce[0] !== 1'b0) begin n_fail++; $display("FAIL pf_ce_T2: got %b want 0", mem_ce[0]); end
      tick();
      @(negedge clk);
      n_tests++; if ({if_rvalid[0], if_rdata[0]} !== 33'd0) begin n_fail++; $display("FAIL pf_rv_T3: got %b/%h want 0/0", if_rvalid[0], if_rdata[0]); end
      tick();
   endtask

   // WAIT_STATES=2: write 0xDEADBEEF to 0x40, then read it back.
   task automatic test_wait_write_read();
      d_req[1] = 1'b1; d_we[1] = 1'b1; d_sel[1] = 4'hF; d_addr[1] = 32'h40; d_wdata[1] = 32'hDEAD_BEEF;
      @(negedge clk);
      n_tests++; if (d_gnt[1] !== 1'b1) begin n_fail++; $display("FAIL ww_gnt_T: got %b want 1", d_gnt[1]); end
      n_tests++; if (mem_we[1] !== 4'hF) begin n_fail++; $display("FAIL ww_we_T: got %h want F", mem_we[1]); end
      n_tests++; if (mem_wdata[1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ww_wdata_T: got %h want deadbeef", mem_wdata[1]); end
      tick();
      d_we[1] = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         n_tests++;
         if ({busy[1], d_gnt[1], mem_ce[1], mem_we[1], mem_addr[1]} !== {1'b1, 1'b0, 1'b1, 4'h0, 32'h40}) begin
            n_fail++; $display("FAIL ww_wait_T%0d: got busy=%b gnt=%b ce=%b we=%h addr=%h want 1 0 1 0 40",
                               k, busy[1], d_gnt[1], mem_ce[1], mem_we[1], mem_addr[1]);
         end
         tick();
      end
      @(negedge clk);
      n_tests++;
      if ({d_gnt[1], busy[1], mem_we[1], mem_addr[1]} !== {1'b1, 1'b0, 4'h0, 32'h40}) begin
         n_fail++; $display("FAIL ww_rdgnt_T3: got gnt=%b busy=%b we=%h addr=%h want 1 0 0 40", d_gnt[1], busy[1], mem_we[1], mem_addr[1]);
      end
      tick();
      d_req[1] = 1'b0;
      for (int k = 4; k <= 7; k++) begin
         @(negedge clk);
         n_tests++;
         if (d_rvalid[1] !== (k == 6)) begin n_fail++; $display("FAIL ww_rv_T%0d: got %b want %b", k, d_rvalid[1], k == 6); end
         if (k == 6) begin
            n_tests++;
            if (d_rdata[1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ww_rdata_T6: got %h want deadbeef", d_rdata[1]); end
         end
         tick();
      end
   endtask

   // WAIT_STATES=0: both requesters hold requests for four cycles.
   task automatic test_priority();
      bit exp_d;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         if_req[0] = 1'b1; if_addr[0] = 32'h300;
         d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h200;
         @(negedge clk);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         exp_d = (k % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         n_tests++;
         if ({d_gnt[0], if_gnt[0]} !== {exp_d, !exp_d}) begin
            n_fail++; $display("FAIL prio_%0d: got d_gnt=%b if_gnt=%b want %b %b", k, d_gnt[0], if_gnt[0], exp_d, !exp_d);
         end
      end
      tick();
      clear_inputs();
      tick();
   endtask

   // One data access on instance i; ok reports grant (and rvalid for reads) within the bound.
   task automatic d_access(input int i, input bit we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, output bit ok, output logic [31:0] rdata);
      bit got_gnt = 0;
      bit got_rv  = 0;
      rdata = 32'd0;
      d_req[i] = 1'b1; d_we[i] = we; d_sel[i] = sel; d_addr[i] = addr; d_wdata[i] = wdata;
      for (int k = 0; k < 20 && !got_gnt; k++) begin
         @(negedge clk);
         got_gnt = d_gnt[i];
         tick();
      end
      d_req[i] = 1'b0;
      if (!we) begin
         for (int k = 0; k < 20 && !got_rv; k++) begin
            @(negedge clk);
            if (d_rvalid[i]) begin got_rv = 1; rdata = d_rdata[i]; end
            tick();
         end
      end
      ok = got_gnt && (we || got_rv);
   endtask

   // Byte-lane write into an existing word (WAIT_STATES=2 instance).
   task automatic test_byte_write();
      bit          ok;
      logic [31:0] rd;
      d_access(1, 1'b1, 4'hF, 32'h80, 32'h1122_3344, ok, rd);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL bw_full_write: got timeout want grant"); end
      d_access(1, 1'b1, 4'b0010, 32'h80, 32'h0000_AB00, ok, rd);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL bw_byte_write: got timeout want grant"); end
      d_access(1, 1'b0, 4'h0, 32'h80, 32'd0, ok, rd);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL bw_read: got timeout want rvalid"); end
      n_tests++; if (rd !== 32'h1122_AB44) begin n_fail++; $display("FAIL bw_data: got %h want 1122ab44", rd); end
   endtask

   // WAIT_STATES=3: reset in the second WAIT cycle of a fetch read.
   task automatic test_reset_in_wait();
      int          if_rv_cnt = 0;
      int          d_rv_at   = -1;
      logic [31:0] d_dat     = 32'd0;
      if_req[2] = 1'b1; if_addr[2] = 32'h20;
      @(negedge clk);
      n_tests++; if (if_gnt[2] !== 1'b1) begin n_fail++; $display("FAIL rw_gnt: got %b want 1", if_gnt[2]); end
      tick();
      if_req[2] = 1'b0;
      @(negedge clk);
      n_tests++; if (busy[2] !== 1'b1) begin n_fail++; $display("FAIL rw_busy: got %b want 1", busy[2]); end
      tick();
      rst_n = 1'b0;
      #1;
      n_tests++; if (outs_of(2) !== 138'd0) begin n_fail++; $display("FAIL rw_reset_outs: got %h want 0", outs_of(2)); end
      tick();
      rst_n = 1'b1;
      d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h44;
      @(negedge clk);
      n_tests++; if (d_gnt[2] !== 1'b1) begin n_fail++; $display("FAIL rw_first_gnt: got %b want 1", d_gnt[2]); end
      for (int k = 1; k <= 8; k++) begin
         tick();
         d_req[2] = 1'b0;
         @(negedge clk);
         if (if_rvalid[2]) if_rv_cnt++;
         if (d_rvalid[2] && d_rv_at < 0) begin d_rv_at = k; d_dat = d_rdata[2]; end
      end
      n_tests++; if (if_rv_cnt !== 0) begin n_fail++; $display("FAIL rw_stale_rv: got %0d want 0", if_rv_cnt); end
      n_tests++; if (d_rv_at !== 4) begin n_fail++; $display("FAIL rw_d_rv_cycle: got %0d want 4", d_rv_at); end
      n_tests++; if (d_dat !== init_word(32'h11)) begin n_fail++; $display("FAIL rw_d_data: got %h want %h", d_dat, init_word(32'h11)); end
      tick();
   endtask

   // Random requests checked cycle by cycle against a scoreboard: the port is free again
   // 1+W cycles after a grant, and read data for a grant at cycle c appears at cycle c+1+W.
   task automatic test_random(input int i, input int ncyc);
      int          w;
      int          free_cyc;
      bit          last_d, fr, dr, idle, eg_d, eg_f, df, exp_dv, exp_fv, wr;
      logic [31:0] shadow [16];
      logic [31:0] held_addr, exp_dat, exp_addr;
      rv_t         q[$];
      rv_t         e;
      int          idx;
      w = ws_of(i);
      free_cyc = 0; last_d = 0; fr = 0; dr = 0; held_addr = 32'd0;
      do_reset();
      for (int k = 0; k < 16; k++) shadow[k] = init_word(k);
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) tick();
         if (!fr && $urandom_range(0, 1) == 1) begin
            fr = 1; if_addr[i] = 32'($urandom_range(0, 15)) << 2;
         end
         if (!dr && $urandom_range(0, 9) < 6) begin
            dr = 1;
            d_we[i] = 1'($urandom_range(0, 1));
            d_sel[i] = 4'($urandom_range(0, 15));
            d_addr[i] = 32'($urandom_range(0, 15)) << 2;
            d_wdata[i] = $urandom;
         end
         if_req[i] = fr; d_req[i] = dr;
         @(negedge clk);
         idle = (c >= free_cyc);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         df = !last_d;
`else
         df = 1'b1;
`endif
         eg_d = idle && dr && (!fr || df);
         eg_f = idle && fr && !eg_d;
         wr = eg_d && d_we[i];
         exp_addr = eg_d ? d_addr[i] : eg_f ? if_addr[i] : !idle ? held_addr : 32'd0;
         exp_dv = 0; exp_fv = 0; exp_dat = 32'd0;
         if (q.size() > 0 && q[0].cyc == c) begin
            e = q.pop_front();
            exp_dv = e.own_d; exp_fv = !e.own_d; exp_dat = e.dat;
         end
         n_tests++;
         if ({if_gnt[i], d_gnt[i], busy[i]} !== {eg_f, eg_d, !idle}) begin
            n_fail++; $display("FAIL rnd%0d_gnt c=%0d: got f=%b d=%b busy=%b want %b %b %b", i, c, if_gnt[i], d_gnt[i], busy[i], eg_f, eg_d, !idle);
         end
         n_tests++;
         if ({mem_ce[i], mem_addr[i]} !== {eg_d || eg_f || !idle, exp_addr}) begin
            n_fail++; $display("FAIL rnd%0d_mem c=%0d: got ce=%b addr=%h want %b %h", i, c, mem_ce[i], mem_addr[i], eg_d || eg_f || !idle, exp_addr);
         end
         n_tests++;
         if ({mem_we[i], mem_wdata[i]} !== {wr ? d_sel[i] : 4'h0, wr ? d_wdata[i] : 32'd0}) begin
            n_fail++; $display("FAIL rnd%0d_wr c=%0d: got we=%h wdata=%h want %h %h", i, c, mem_we[i], mem_wdata[i], wr ? d_sel[i] : 4'h0, wr ? d_wdata[i] : 32'd0);
         end
         n_tests++;
         if ({d_rvalid[i], d_rdata[i]} !== {exp_dv, exp_dv ? exp_dat : 32'd0}) begin
            n_fail++; $display("FAIL rnd%0d_drv c=%0d: got %b/%h want %b/%h", i, c, d_rvalid[i], d_rdata[i], exp_dv, exp_dv ? exp_dat : 32'd0);
         end
         n_tests++;
         if ({if_rvalid[i], if_rdata[i]} !== {exp_fv, exp_fv ? exp_dat : 32'd0}) begin
            n_fail++; $display("FAIL rnd%0d_frv c=%0d: got %b/%h want %b/%h", i, c, if_rvalid[i], if_rdata[i], exp_fv, exp_fv ? exp_dat : 32'd0);
         end
         if (eg_d || eg_f) begin
            free_cyc = c + 1 + w;
            held_addr = exp_addr;
            last_d = eg_d;
            idx = int'(exp_addr[5:2]);
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (d_sel[i][b]) shadow[idx][8*b +: 8] = d_wdata[i][8*b +: 8];
            end else begin
               e.cyc = c + 1 + w; e.own_d = eg_d; e.dat = shadow[idx];
               q.push_back(e);
            end
            if (eg_d) dr = 0;
            if (eg_f) fr = 0;
         end
      end
      tick();
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      mem_init = 1'b1;
      clear_inputs();
      test_reset();
      clear_inputs();
      tick();
      mem_init = 1'b0;
      tick();
      rst_n = 1'b1;
      test_pipelined_fetch();
      test_wait_write_read();
      test_priority();
      test_byte_write();
      test_reset_in_wait();
      test_random(0, 400);
      test_random(1, 400);
      test_random(2, 400);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
